// File: rtl/kmac_msg_packer.sv
// Packs byte-strobed message beats densely into wider output beats with a byte strobe and bit mask.
// Optional strobe-contiguity checking is enabled by defining KMAC_PACKER_STRB_CHECK_EN.
module kmac_msg_packer #(
    parameter int InW  = 64,
    parameter int OutW = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [InW-1:0]      data_i,
    input  logic [InW/8-1:0]    strb_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [OutW-1:0]     data_o,
    output logic [OutW/8-1:0]   strb_o,
    output logic [OutW-1:0]     mask_o,
    output logic                last_o,
    input  logic                ready_i,
    output logic                err_o
);

    localparam int InB   = InW / 8;
    localparam int OutB  = OutW / 8;
    localparam int BufW  = OutW + InW;
    localparam int BufB  = BufW / 8;
    localparam int FillW = $clog2(BufB + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StFlush} state_e;

    state_e            state_q, state_d;
    logic [BufW-1:0]   buf_q, buf_d, buf_s;
    logic [FillW-1:0]  fill_q, fill_d, fill_s;
    logic [FillW-1:0]  in_cnt;
    logic [InW-1:0]    in_bytes;
    logic              in_hs, out_hs;

    // Strobed bytes are always the low in_cnt bytes, so compaction is just zeroing the rest.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < InB; i++) begin
            in_cnt = in_cnt + FillW'(strb_i[i]);
        end
`ifdef KMAC_PACKER_STRB_CHECK_EN
        if ((strb_i & (strb_i + InB'(1))) != '0) begin
            in_cnt = '0;
        end
`endif
        in_bytes = '0;
        for (int i = 0; i < InB; i++) begin
            in_bytes[8*i +: 8] = (i < int'(in_cnt)) ? data_i[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        valid_o = (fill_q >= FillW'(OutB)) || (state_q == StFlush);
        last_o  = (state_q == StFlush) && (fill_q <= FillW'(OutB));
        for (int i = 0; i < OutB; i++) begin
            strb_o[i]        = (i < int'(fill_q));
            mask_o[8*i +: 8] = {8{strb_o[i]}};
        end
        data_o  = buf_q[OutW-1:0] & mask_o;
        ready_o = rst_ni && (state_q != StFlush) &&
                  ((fill_q < FillW'(OutB)) || (valid_o && ready_i));
        in_hs   = valid_i && ready_o;
        out_hs  = valid_o && ready_i;
    end

    // The output shift is applied first so a same-cycle input lands behind the surviving bytes.
    always_comb begin
        buf_s   = out_hs ? (buf_q >> OutW) : buf_q;
        fill_s  = out_hs ? ((fill_q > FillW'(OutB)) ? fill_q - FillW'(OutB) : '0) : fill_q;
        buf_d   = buf_s;
        fill_d  = fill_s;
        state_d = state_q;
        if (in_hs) begin
            buf_d  = buf_s | (BufW'(in_bytes) << (8 * int'(fill_s)));
            fill_d = fill_s + in_cnt;
            if (last_i) begin
                state_d = StFlush;
            end else if (state_q == StIdle) begin
                state_d = StAccum;
            end
        end
        if (out_hs && last_o) begin
            state_d = StIdle;
            fill_d  = '0;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

`ifdef KMAC_PACKER_STRB_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (in_hs && ((strb_i & (strb_i + InB'(1))) != '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
